// File: rtl/spi_rx_byte_fifo_pkg.sv
// Shared constants and helpers for the single-clock SPI receive byte FIFO.
package spi_pkg;

  localparam int SPI_DSIZE  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;

  // Chip select is active-low: capture is enabled only while spi_cs equals this.
  localparam logic CS_ACTIVE = 1'b0;

  // What the FIFO does in a given cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/spi_rx_byte_fifo_if.sv
// Receive-side bundle: receiver strobe/byte in, consumer valid/ready stream out.
// The master modport is the FIFO block; the slave modport is its environment.
interface spi_rx_byte_fifo_if
  import spi_pkg::*;
#(
  parameter int DSIZE = SPI_DSIZE,
  parameter int AW    = FIFO_AW
) ();

  logic             spi_cs;
  logic             control_clk_miso;
  logic [DSIZE-1:0] spi_miso_out;
  logic [DSIZE-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [AW:0]      rx_count;
  logic             rx_full;
  logic             rx_overflow;
  logic             ovf_clr;

  modport master (
    input  spi_cs, control_clk_miso, spi_miso_out, rx_ready, ovf_clr,
    output rx_data, rx_valid, rx_count, rx_full, rx_overflow
  );

  modport slave (
    output spi_cs, control_clk_miso, spi_miso_out, rx_ready, ovf_clr,
    input  rx_data, rx_valid, rx_count, rx_full, rx_overflow
  );

endinterface

// File: rtl/spi_rx_byte_fifo_fifo.sv
// Small synchronous first-word-fall-through FIFO. Full/empty are derived from
// the occupancy counter so the pointers can simply wrap.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DSIZE = SPI_DSIZE,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rd_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A read can only happen with data present; a write into a full FIFO is
  // only allowed when a read frees the head slot in the same cycle.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state from this cycle's read/write combination.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (fifo_op(wr_ok, rd_ok))
      FIFO_PUSH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end
      FIFO_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      FIFO_IDLE: begin
      end
    endcase
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; stale entries are hidden by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spi_rx_byte_fifo.sv
// Receive-path byte buffer in the spi_clk domain: detects rising edges of the
// receiver's byte strobe, captures the byte into a FIFO, and hands bytes to the
// consumer over valid/ready with a sticky overflow flag.
module spi_rx_byte_fifo
  import spi_pkg::*;
#(
  parameter int DSIZE = SPI_DSIZE,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic                 spi_clk,
  input  logic                 n_reset,
  spi_rx_byte_fifo_if.master   bus
);

  logic t1_q, t1_d;
  logic ovf_q, ovf_d;
  logic rise;
  logic push;
  logic pop;
  logic drop;
  logic fifo_full;
  logic fifo_empty;

  // A rise is a high strobe that was low at the previous edge, so at most one
  // byte can be accepted every two cycles.
  assign rise = bus.control_clk_miso & ~t1_q;
  assign push = rise & (bus.spi_cs == CS_ACTIVE);
  assign pop  = ~fifo_empty & bus.rx_ready;
  assign drop = push & fifo_full & ~pop;

  assign bus.rx_valid    = ~fifo_empty;
  assign bus.rx_full     = fifo_full;
  assign bus.rx_overflow = ovf_q;

  // Strobe history and overflow flag next-state; a fresh drop beats a clear.
  always_comb begin
    t1_d  = bus.control_clk_miso;
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Strobe history and overflow registers with synchronous active-low reset.
  always_ff @(posedge spi_clk) begin
    if (!n_reset) begin
      t1_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      t1_q  <= t1_d;
      ovf_q <= ovf_d;
    end
  end

  spi_sync_fifo #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (spi_clk),
    .n_reset   (n_reset),
    .wr_en_i   (push),
    .wr_data_i (bus.spi_miso_out),
    .rd_en_i   (pop),
    .rd_data_o (bus.rx_data),
    .count_o   (bus.rx_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_spi_rx_byte_fifo.sv
// Self-checking bench for spi_rx_byte_fifo: directed scenarios with fixed
// expectations, then randomized traffic against a queue-based reference model.
module tb_spi_rx_byte_fifo;
  import spi_pkg::*;

  logic spi_clk = 1'b0;
  logic n_reset;
  int   checks = 0;
  int   errors = 0;

  // Reference model: bytes held, last strobe level seen, sticky overflow.
  logic [7:0] mq[$];
  bit         m_t1;
  bit         m_ovf;

  spi_rx_byte_fifo_if bus ();

  spi_rx_byte_fifo dut (
    .spi_clk (spi_clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // Free-running spi_clk, 10 time units per period.
  always #5 spi_clk = ~spi_clk;

  // Advance one edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    bit rise, push, pop, dropped;
    rise    = bus.control_clk_miso && !m_t1;
    push    = rise && (bus.spi_cs == 1'b0);
    pop     = (mq.size() != 0) && bus.rx_ready;
    dropped = 1'b0;
    @(posedge spi_clk);
    if (!n_reset) begin
      mq.delete();
      m_t1  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_t1 = bus.control_clk_miso;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back(bus.spi_miso_out);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.spi_miso_out     = d;
    bus.control_clk_miso = 1'b1;
    tick();
    bus.control_clk_miso = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    bus.control_clk_miso = 1'b1;
    tick();
    bus.control_clk_miso = 1'b0;
    tick();
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_count !== 4'd0 || bus.rx_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got valid=%b count=%0d ovf=%b want 0/0/0",
               bus.rx_valid, bus.rx_count, bus.rx_overflow);
    end
    checks++;
    if (bus.rx_data !== 8'h00 || bus.rx_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data got data=%h full=%b want 00/0", bus.rx_data, bus.rx_full);
    end
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    bus.spi_miso_out     = 8'hA5;
    bus.control_clk_miso = 1'b1;
    tick();
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA5 || bus.rx_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL single_latency got valid=%b data=%h count=%0d want 1/a5/1",
               bus.rx_valid, bus.rx_data, bus.rx_count);
    end
    bus.control_clk_miso = 1'b0;
    tick();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_count !== 4'd0 || bus.rx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_pop got valid=%b count=%0d data=%h want 0/0/00",
               bus.rx_valid, bus.rx_count, bus.rx_data);
    end
  endtask

  task automatic test_cs_gating();
    bus.spi_cs = 1'b1;
    for (int i = 0; i < 3; i++) strobe(8'h3C);
    bus.spi_cs = 1'b0;
    checks++;
    if (bus.rx_count !== 4'd0 || bus.rx_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cs_gating got count=%0d ovf=%b want 0/0", bus.rx_count, bus.rx_overflow);
    end
  endtask

  task automatic test_fill_overflow();
    bus.rx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      strobe(8'(i));
      if (i == 7) begin
        checks++;
        if (bus.rx_full !== 1'b0 || bus.rx_count !== 4'd7) begin
          errors++;
          $display("[TB] FAIL fill_seven got full=%b count=%0d want 0/7", bus.rx_full, bus.rx_count);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.rx_full !== 1'b1 || bus.rx_count !== 4'd8 || bus.rx_overflow !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fill_eight got full=%b count=%0d ovf=%b want 1/8/0",
                   bus.rx_full, bus.rx_count, bus.rx_overflow);
        end
      end
    end
    checks++;
    if (bus.rx_overflow !== 1'b1 || bus.rx_count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL overflow_drop got ovf=%b count=%0d want 1/8", bus.rx_overflow, bus.rx_count);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL drain_order[%0d] got valid=%b data=%h want 1/%h",
                 i, bus.rx_valid, bus.rx_data, 8'(i));
      end
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
    end
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drained_sticky got valid=%b ovf=%b want 0/1", bus.rx_valid, bus.rx_overflow);
    end
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.rx_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear got %b want 0", bus.rx_overflow);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] expq[$];
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) strobe(8'h10 + 8'(i));
    bus.spi_miso_out     = 8'hEE;
    bus.control_clk_miso = 1'b1;
    bus.rx_ready         = 1'b1;
    tick();
    bus.rx_ready         = 1'b0;
    bus.control_clk_miso = 1'b0;
    checks++;
    if (bus.rx_count !== 4'd8 || bus.rx_overflow !== 1'b0 || bus.rx_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL push_pop_full got count=%0d ovf=%b head=%h want 8/0/11",
               bus.rx_count, bus.rx_overflow, bus.rx_data);
    end
    tick();
    expq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hEE};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.rx_data !== expq[i]) begin
        errors++;
        $display("[TB] FAIL push_pop_drain[%0d] got %h want %h", i, bus.rx_data, expq[i]);
      end
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) strobe(8'h40 + 8'(i));
    n_reset = 1'b0;
    #2;
    checks++;
    if (bus.rx_count !== 4'd5) begin
      errors++;
      $display("[TB] FAIL reset_waits_edge got count=%0d want 5", bus.rx_count);
    end
    tick();
    checks++;
    if (bus.rx_count !== 4'd0 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid got count=%0d valid=%b want 0/0", bus.rx_count, bus.rx_valid);
    end
    n_reset = 1'b1;
    strobe(8'h77);
    checks++;
    if (bus.rx_count !== 4'd1 || bus.rx_data !== 8'h77) begin
      errors++;
      $display("[TB] FAIL reset_mid_next got count=%0d data=%h want 1/77", bus.rx_count, bus.rx_data);
    end
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_only got valid=%b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_random();
    logic [14:0] exp_s, got_s;
    logic [7:0]  head;
    for (int c = 0; c < 600; c++) begin
      bus.spi_cs           = ($urandom_range(0, 7) == 0);
      bus.control_clk_miso = 1'($urandom_range(0, 1));
      bus.spi_miso_out     = 8'($urandom);
      bus.rx_ready         = ($urandom_range(0, 2) == 0);
      bus.ovf_clr          = ($urandom_range(0, 15) == 0);
      n_reset              = ($urandom_range(0, 99) != 0);
      tick();
      head  = (mq.size() != 0) ? mq[0] : 8'h00;
      exp_s = {mq.size() != 0, 4'(mq.size()), mq.size() == FIFO_DEPTH, m_ovf, head};
      got_s = {bus.rx_valid, bus.rx_count, bus.rx_full, bus.rx_overflow, bus.rx_data};
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("[TB] FAIL random[%0d] got v/cnt/full/ovf/data=%h want %h", c, got_s, exp_s);
      end
    end
    n_reset              = 1'b1;
    bus.control_clk_miso = 1'b0;
    bus.rx_ready         = 1'b0;
    bus.ovf_clr          = 1'b0;
    bus.spi_cs           = 1'b0;
  endtask

  initial begin
    n_reset              = 1'b0;
    bus.spi_cs           = 1'b0;
    bus.control_clk_miso = 1'b0;
    bus.spi_miso_out     = 8'h00;
    bus.rx_ready         = 1'b0;
    bus.ovf_clr          = 1'b0;
    m_t1                 = 1'b0;
    m_ovf                = 1'b0;
    #2;
    $display("[TB] starting spi_rx_byte_fifo bench");
    test_reset();
    test_single_byte();
    test_cs_gating();
    test_fill_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_rx_byte_fifo.md
Name: spi_rx_byte_fifo

Overview:
Downstream stage of the SPI receive path, in the spi_clk domain.
- Detects each rising edge of the receiver's byte strobe (control_clk_miso).
- Captures the receiver's parallel byte (spi_miso_out) one cycle later and buffers it in a small synchronous FIFO.
- Presents bytes to the consumer over a valid/ready handshake, with occupancy count and sticky overflow flag.
- Replaces the dual-clock FIFO on the receive path: everything runs on spi_clk.

Parameters:
DSIZE, 8, byte width; must match the receiver's output width.
DEPTH, 8, FIFO entries; power of two.
AW, 3, pointer width, log2(DEPTH).

Ports:
spi_clk  input  1  sole clock; all logic on rising edge.
n_reset  input  1  reset, synchronous and active-low.
spi_cs  input  1  chip select, active-low; high suppresses capture.
control_clk_miso  input  1  byte strobe from receiver; level, rising edge = new byte.
spi_miso_out  input  DSIZE  received byte from receiver.
rx_data  output  DSIZE  head-of-FIFO byte.
rx_valid  output  1  FIFO non-empty.
rx_ready  input  1  consumer accepts head when rx_valid high.
rx_count  output  AW+1  occupancy, 0..DEPTH.
rx_full  output  1  rx_count == DEPTH.
rx_overflow  output  1  sticky: a byte was dropped.
ovf_clr  input  1  clears rx_overflow.

Behaviour:
- Reset:
  - Applied only at a spi_clk edge with n_reset=0.
  - Clears strobe history (t1=0), write pointer, read pointer, count, rx_overflow.
  - rx_valid=0, rx_full=0, rx_count=0, rx_data=0.
  - Memory contents are don't-care.
  - Reset mid-transfer discards all buffered bytes. The first edge after release cannot report a rise unless control_clk_miso is already high at that edge.
- Strobe detection:
  - t1 <= control_clk_miso every edge.
  - rise = control_clk_miso & ~t1.
  - Falling edges are ignored.
- Capture:
  - push = rise & ~spi_cs, evaluated at the edge following the strobe's rising edge.
  - spi_miso_out is sampled at that edge; it is settled by then.
  - Latency: byte visible on rx_data/rx_valid 1 spi_clk after control_clk_miso rises, when FIFO was empty.
  - spi_cs high at that edge: no push, no overflow.
- Pop:
  - pop = rx_valid & rx_ready.
  - First-word fall-through: rx_data = mem[rd_ptr], combinational from registered storage.
  - rx_data = 0 when empty.
- Push/pop interaction:
  - Push and pop in the same cycle: both performed, count unchanged.
  - When full, a push is accepted only if pop is also asserted that cycle.
  - Push when full without pop: byte dropped, pointers and count unchanged, rx_overflow <= 1.
  - Pop when empty is impossible, since rx_ready is ignored while rx_valid=0.
- Pointers:
  - AW bits wide; wrap naturally DEPTH-1 -> 0.
  - Full/empty come from rx_count, not pointer comparison.
- Overflow:
  - ovf_clr=1 clears rx_overflow.
  - A new drop in the same cycle as ovf_clr takes priority: flag stays 1.
- Back-to-back strobes:
  - Receiver produces at most one rise per 16 spi_clk.
  - The block accepts one rise per 2 cycles, since a rise needs t1=0.

Decomposition:
- Shared package spi_pkg: DSIZE default, FIFO DEPTH/AW constants, CS_ACTIVE=1'b0.
- One natural sub-module: spi_sync_fifo (storage, pointers, count, full/empty), instantiated under the strobe-detect/capture wrapper.

Test Plan:
- Reset: hold n_reset=0 for 2 edges with strobe toggling -> rx_valid=0, rx_count=0, rx_overflow=0. Reset not applied until a spi_clk edge.
- Single byte: spi_cs=0, spi_miso_out=8'hA5, control_clk_miso rises -> next edge rx_valid=1, rx_data=8'hA5, rx_count=1. rx_ready=1 one cycle -> rx_valid=0.
- CS gating: spi_cs=1, 3 strobe rises with 8'h3C -> rx_count stays 0, rx_overflow=0.
- Fill/overflow:
  - rx_ready=0, push 9 bytes 8'h01..8'h09 -> rx_full=1 after 8th, 9th dropped, rx_overflow=1.
  - Drain -> 8'h01..8'h08 in order, pointer wrap exercised.
  - ovf_clr -> rx_overflow=0.
- Simultaneous push/pop at full: full FIFO, rx_ready=1 in the push cycle with 8'hEE -> no overflow, count stays 8, 8'hEE read last.
- Reset mid-operation: 5 bytes buffered, n_reset=0 one edge -> rx_count=0, rx_valid=0. The next strobe's byte is the only one read out.
